// File: rtl/prot_reg_pkg.sv
// Shared types and constants for the protected-register request path.
// Optional deny filter: PROT_REQ_DENY_FILTER_EN.
package prot_reg_pkg;

    localparam int PROT_ID_W   = 3;
    localparam int PROT_DATA_W = 8;
    localparam int DENY_CNT_W  = 8;

    localparam logic [PROT_ID_W-1:0] PROT_AUTH_ID = 3'h4;

    typedef struct packed {
        logic [PROT_ID_W-1:0]   usr_id;
        logic [PROT_DATA_W-1:0] data;
    } prot_req_t;

    function automatic logic [DENY_CNT_W-1:0] sat_inc(
        input logic [DENY_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/prot_reg_req_arb_rr_arbiter.sv
// Combinational one-hot round-robin grant.
// Scans upward from last+1 with wrap; i_en gates every grant.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PW    = $clog2(N_REQ)
) (
    input  logic             i_en,
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_last,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PW-1:0]    o_idx,
    output logic             o_any
);

    // last <= N_REQ-1 and offset <= N_REQ, so PW+1 bits never overflow
    logic [PW:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = {1'b0, i_last} + (PW+1)'(i);
            if (w_cand >= (PW+1)'(N_REQ)) begin
                w_cand = w_cand - (PW+1)'(N_REQ);
            end
            if (i_en && !o_any && i_req[w_cand[PW-1:0]]) begin
                o_any                = 1'b1;
                o_gnt[w_cand[PW-1:0]] = 1'b1;
                o_idx                = w_cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/prot_reg_req_arb.sv
// Round-robin request arbiter with atomic {id, data} capture slot.
// Define PROT_REQ_DENY_FILTER_EN to drop and count unauthorized IDs.
module prot_reg_req_arb
    import prot_reg_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int ID_W   = PROT_ID_W,
    parameter  int DATA_W = PROT_DATA_W,
`ifdef PROT_REQ_DENY_FILTER_EN
    parameter  logic [ID_W-1:0] AUTH_ID = PROT_AUTH_ID,
`endif
    localparam int PW     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ID_W-1:0]   req_usr_id,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_usr_id,
    output logic [DATA_W-1:0]       out_data,
`ifdef PROT_REQ_DENY_FILTER_EN
    output logic [DENY_CNT_W-1:0]   deny_cnt,
`endif
    output logic [PW-1:0]           out_src
);

    logic                r_valid;
    prot_req_t           r_slot;
    logic [PW-1:0]       r_src;
    logic [PW-1:0]       r_last;

    logic                w_slot_free;
    logic [N_REQ-1:0]    w_gnt;
    logic [PW-1:0]       w_idx;
    logic                w_any;
    logic                w_fwd;
    prot_req_t           w_sel;

    assign w_slot_free = !r_valid || out_ready;

    // Reset forces req_ready low even while requesters hold valid
    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_en   (w_slot_free && rst_n),
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign req_ready = w_gnt;

    always_comb begin
        w_sel        = '0;
        w_sel.usr_id = req_usr_id[w_idx*ID_W +: ID_W];
        w_sel.data   = req_data[w_idx*DATA_W +: DATA_W];
    end

`ifdef PROT_REQ_DENY_FILTER_EN
    logic                  w_deny;
    logic [DENY_CNT_W-1:0] r_deny_cnt;

    assign w_deny = w_any && (w_sel.usr_id != AUTH_ID);
    assign w_fwd  = w_any && !w_deny;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deny_cnt <= '0;
        end else if (w_deny) begin
            r_deny_cnt <= sat_inc(r_deny_cnt);
        end
    end

    assign deny_cnt = r_deny_cnt;
`else
    assign w_fwd = w_any;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
            r_src   <= '0;
            r_last  <= PW'(N_REQ-1);
        end else if (w_slot_free) begin
            r_valid <= w_fwd;
            if (w_any) begin
                r_last <= w_idx;
            end
            if (w_fwd) begin
                r_slot <= w_sel;
                r_src  <= w_idx;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_usr_id = r_slot.usr_id;
    assign out_data   = r_slot.data;
    assign out_src    = r_src;

endmodule

// File: tb/tb_prot_reg_req_arb.sv
// Directed vector bench for prot_reg_req_arb.
// Deny-filter checks run when PROT_REQ_DENY_FILTER_EN is defined.
module tb_prot_reg_req_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_usr_id;
    logic [31:0] req_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_usr_id;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
`ifdef PROT_REQ_DENY_FILTER_EN
    logic [7:0]  deny_cnt;
`endif

    int n_pass;
    int n_tot;

    prot_reg_req_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_usr_id (req_usr_id),
        .req_data   (req_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_usr_id (out_usr_id),
        .out_data   (out_data),
`ifdef PROT_REQ_DENY_FILTER_EN
        .deny_cnt   (deny_cnt),
`endif
        .out_src    (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [11:0] ids;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_src;
        logic [2:0]  e_id;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(
        input logic rst, input logic [3:0] rv,
        input logic [11:0] ids, input logic [31:0] dat,
        input logic ordy, input logic [3:0] e_rdy,
        input logic e_ov, input logic [1:0] e_src,
        input logic [2:0] e_id, input logic [7:0] e_dat
    );
        vec_t v;
        v.rst = rst; v.rv = rv; v.ids = ids; v.dat = dat;
        v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov;
        v.e_src = e_src; v.e_id = e_id; v.e_dat = e_dat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass     = 0;
        n_tot      = 0;
        req_usr_id = '0;
        req_data   = '0;

        tbl[0]  = mk(1, 4'b0100, {3'd0,3'd4,3'd0,3'd0},
                     32'h00AB0000, 1, 4'b0100, 1, 2, 4, 8'hAB);
        tbl[1]  = mk(0, 4'b0000, {3'd0,3'd4,3'd0,3'd0},
                     32'h00AB0000, 1, 4'b0000, 0, 2, 4, 8'hAB);
        tbl[2]  = mk(1, 4'b1111, {4{3'd4}},
                     32'h13121110, 1, 4'b0001, 1, 0, 4, 8'h10);
        tbl[3]  = mk(0, 4'b1111, {4{3'd4}},
                     32'h13121110, 1, 4'b0010, 1, 1, 4, 8'h11);
        tbl[4]  = mk(0, 4'b1111, {4{3'd4}},
                     32'h13121110, 1, 4'b0100, 1, 2, 4, 8'h12);
        tbl[5]  = mk(0, 4'b1111, {4{3'd4}},
                     32'h13121110, 1, 4'b1000, 1, 3, 4, 8'h13);
        tbl[6]  = mk(0, 4'b1111, {4{3'd4}},
                     32'h13121110, 1, 4'b0001, 1, 0, 4, 8'h10);
        tbl[7]  = mk(1, 4'b0001, {4{3'd4}},
                     32'h000055AB, 1, 4'b0001, 1, 0, 4, 8'hAB);
        tbl[8]  = mk(0, 4'b0010, {4{3'd4}},
                     32'h000055AB, 0, 4'b0000, 1, 0, 4, 8'hAB);
        tbl[9]  = mk(0, 4'b0010, {4{3'd4}},
                     32'h000055AB, 0, 4'b0000, 1, 0, 4, 8'hAB);
        tbl[10] = mk(0, 4'b0010, {4{3'd4}},
                     32'h000055AB, 0, 4'b0000, 1, 0, 4, 8'hAB);
        tbl[11] = mk(0, 4'b0010, {4{3'd4}},
                     32'h000055AB, 1, 4'b0010, 1, 1, 4, 8'h55);
        tbl[12] = mk(0, 4'b0000, {4{3'd4}},
                     32'h000055AB, 1, 4'b0000, 0, 1, 4, 8'h55);

        do_reset();
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_usr_id", 32'(out_usr_id), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst out_src", 32'(out_src), 0);

        for (int k = 0; k < 13; k++) begin
            if (tbl[k].rst) do_reset();
            else @(negedge clk);
            req_valid  = tbl[k].rv;
            req_usr_id = tbl[k].ids;
            req_data   = tbl[k].dat;
            out_ready  = tbl[k].ordy;
            #1;
            chk($sformatf("v%0d req_ready", k), 32'(req_ready),
                32'(tbl[k].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", k), 32'(out_valid),
                32'(tbl[k].e_ov));
            chk($sformatf("v%0d out_src", k), 32'(out_src),
                32'(tbl[k].e_src));
            chk($sformatf("v%0d out_usr_id", k), 32'(out_usr_id),
                32'(tbl[k].e_id));
            chk($sformatf("v%0d out_data", k), 32'(out_data),
                32'(tbl[k].e_dat));
        end

        // atomic capture: requester changes id/data right after acceptance
        do_reset();
        req_valid  = 4'b0001;
        req_usr_id = {9'd0, 3'd4};
        req_data   = {24'd0, 8'hAB};
        out_ready  = 1'b0;
        #1;
        chk("atom req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("atom out_valid", 32'(out_valid), 1);
        @(negedge clk);
        req_usr_id = {9'd0, 3'd3};
        req_data   = {24'd0, 8'hCD};
        #1;
        chk("atom blocked rdy", 32'(req_ready), 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("atom id c%0d", c), 32'(out_usr_id), 4);
            chk($sformatf("atom data c%0d", c), 32'(out_data), 32'hAB);
        end

        // reset mid-operation while slot is stalled
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", 32'(out_valid), 0);
        chk("mid rst out_data", 32'(out_data), 0);
        chk("mid rst out_usr_id", 32'(out_usr_id), 0);
        chk("mid rst req_ready", 32'(req_ready), 0);
`ifdef PROT_REQ_DENY_FILTER_EN
        chk("mid rst deny_cnt", 32'(deny_cnt), 0);
`endif
        @(negedge clk);
        rst_n      = 1'b1;
        req_valid  = 4'b1111;
        req_usr_id = {4{3'd4}};
        req_data   = 32'h13121110;
        out_ready  = 1'b1;
        #1;
        chk("post rst req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post rst out_src", 32'(out_src), 0);
        chk("post rst out_data", 32'(out_data), 32'h10);

`ifdef PROT_REQ_DENY_FILTER_EN
        do_reset();
        req_valid  = 4'b0010;
        req_usr_id = {6'd0, 3'd3, 3'd0};
        req_data   = 32'h0000CD00;
        out_ready  = 1'b1;
        #1;
        chk("deny req_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("deny out_valid", 32'(out_valid), 0);
        chk("deny cnt 1", 32'(deny_cnt), 1);
        repeat (299) @(posedge clk);
        #1;
        chk("deny cnt sat", 32'(deny_cnt), 255);
        chk("deny out_valid sat", 32'(out_valid), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/prot_reg_req_arb.md
# prot_reg_req_arb

Round-robin request arbiter and capture stage that sits directly upstream of the user-ID-gated protected register. It collects write requests (user ID + data) from N requesters and forwards one per cycle over a valid/ready link. User ID and data are captured atomically on the same edge, so the downstream access check always evaluates the ID that belongs to the data it writes.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 3: user ID width.
- `DATA_W`, 8: data width.
- `AUTH_ID`, 3'h4: authorized user ID; used only when the deny filter is compiled in.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_usr_id`  in  N_REQ*ID_W  packed IDs, requester i at `[i*ID_W +: ID_W]`.
- `req_data`  in  N_REQ*DATA_W  packed data, same packing.
- `out_valid`  out  1  forwarded request valid.
- `out_ready`  in  1  downstream accepts.
- `out_usr_id`  out  ID_W  forwarded user ID.
- `out_data`  out  DATA_W  forwarded data.
- `out_src`  out  clog2(N_REQ)  index of the granted requester.
- `deny_cnt`  out  8  saturating deny count; present only with the macro.

## Operation
- Single output register slot. `slot_free = !out_valid || out_ready`.
- Arbitration happens only when `slot_free`. The grant goes to the first asserted `req_valid` scanning from `last_grant+1` upward, with modulo-N_REQ wrap.
- `req_ready[g]` = 1 for the granted index only, combinational in the same cycle. A request transfers on `req_valid[g] && req_ready[g]`.
- On transfer:
  - `out_usr_id`, `out_data`, `out_src` load from requester g together.
  - `out_valid` is set.
  - `last_grant <= g`.
- If `slot_free` and no request is valid: `out_valid` clears, data holds its last value, and `last_grant` is unchanged.
- While `out_valid && !out_ready`: all outputs hold stable and `req_ready` is 0.
- Requesters must hold `req_valid`, ID and data stable until accepted. The arbiter does not check this.
- Reset values:
  - `out_valid`=0, `out_usr_id`=0, `out_data`=0, `out_src`=0.
  - `last_grant`=N_REQ-1, so requester 0 has first priority.
  - `deny_cnt`=0.
  - `req_ready` is 0 while reset is asserted.
- Reset asserted mid-transfer drops the held request. No partial state survives.

## Timing
- Latency: one cycle from request acceptance to `out_valid`.
- Throughput: one request per cycle when `out_ready` is held high.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0. No requester waits more than N_REQ-1 transfers.
- Simultaneous drain and load: if `out_ready` is high in the same cycle as a new grant, the slot reloads with no bubble.
- `req_ready` depends combinationally on `out_ready` and `req_valid`. There is no combinational path from any `req_*` input to `out_*`.

## Configuration
- `PROT_REQ_DENY_FILTER_EN`:
  - **Defined:** a granted request with `usr_id != AUTH_ID` is still accepted (`req_ready`=1) but is not forwarded. `out_valid` is not set by it, and `last_grant` still advances. `deny_cnt` increments by 1 and saturates at 255.
  - **Undefined:** every granted request is forwarded, the `deny_cnt` port is absent, and the downstream register performs the only check.

## Structure
- Shared package `prot_reg_pkg`:
  - ID/data width constants.
  - Default `AUTH_ID`.
  - A `prot_req_t` struct {usr_id, data}, used for the slot register.
- One sub-module, `rr_arbiter`: parameterized one-hot round-robin grant from a request vector and the `last_grant` pointer, purely combinational.
- Slot register, pointer, and deny counter live in the top level.

## Test plan
- **Reset then single requester.** Reset, then requester 2 sends id 4, data 0xAB with `out_ready`=1. Required: `req_ready[2]` in the same cycle; next cycle `out_valid`=1, `out_usr_id`=4, `out_data`=0xAB, `out_src`=2.
- **Round-robin.** All 4 requesters valid, `out_ready`=1, data 0x10..0x13. Required: `out_src` sequence 0,1,2,3,0 on consecutive cycles, with no bubbles.
- **Backpressure.** Requester 0 sends 0xAB, then `out_ready`=0 for 3 cycles while requester 1 is valid. Required: outputs hold id/0xAB, `req_ready`=0; when `out_ready` returns to 1, requester 1 loads in the same cycle.
- **Atomic capture.** Requester 0 changes id 4→3 and data 0xAB→0xCD in the cycle after acceptance. Required: forwarded pair is {4, 0xAB}, never {3, 0xAB}.
- **Deny filter (macro defined).** Requester 1 sends id 3, data 0xCD. Required: accepted, `out_valid` stays 0, `deny_cnt`=1. After 300 such requests, `deny_cnt`=255.
- **Reset mid-operation.** Assert `rst_n`=0 while `out_valid`=1 and `out_ready`=0. Required: `out_valid`, `out_data` and `deny_cnt` go to 0 immediately; the first post-reset grant goes to requester 0.
